// File: rtl/uart_pkg.sv
// Constants shared by the UART receive FIFO and the UART transmitter.
package uart_pkg;
  localparam int DATA_W      = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;
endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO: captures one byte per rising edge of the receiver's frame-done
// level and presents it first-word fall-through to the consumer.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_status,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              status_q;
  logic              overflow_q, overflow_d;
  logic              pushEvent, isFull, isEmpty, doPush, doPop, ovfEvent;

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  always_comb begin
    pushEvent  = rx_status & ~status_q;
    isFull     = (count_q == FULL_COUNT);
    isEmpty    = (count_q == '0);
    doPop      = rd_en & ~isEmpty;
    doPush     = pushEvent & (~isFull | doPop);
    ovfEvent   = pushEvent & isFull & ~doPop;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (doPush) wrPtr_d = wrPtr_q + ADDR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + ADDR_W'(1);
    if (doPush && !doPop)      count_d = count_q + (ADDR_W + 1)'(1);
    else if (doPop && !doPush) count_d = count_q - (ADDR_W + 1)'(1);
    if (ovfEvent)     overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  // status_q resets high so a level already present at reset release is not a push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      status_q   <= 1'b1;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      status_q   <= rx_status;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && doPush) mem[wrPtr_q] <= rx_data;
  end

  assign rd_data  = isEmpty ? '0 : mem[rdPtr_q];
  assign rd_valid = ~isEmpty;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       overflow;
  logic       clr_ovf;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  logic [7:0] modelQ[$];
  logic       modelPrev = 1'b1;
  logic       modelOvf  = 1'b0;

  uart_rx_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_status(rx_status),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue updated from the behavioural rules at each edge.
  always @(posedge clk) begin
    if (!reset) begin
      modelQ.delete();
      modelOvf  = 1'b0;
      modelPrev = 1'b1;
    end else begin
      automatic bit push    = rx_status && !modelPrev;
      automatic bit pop     = rd_en && (modelQ.size() > 0);
      automatic bit wasFull = (modelQ.size() == DEPTH);
      automatic bit ovfEv   = 1'b0;
      if (pop) void'(modelQ.pop_front());
      if (push) begin
        if (!wasFull || pop) modelQ.push_back(rx_data);
        else ovfEv = 1'b1;
      end
      if (ovfEv) modelOvf = 1'b1;
      else if (clr_ovf) modelOvf = 1'b0;
      modelPrev = rx_status;
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      automatic logic [7:0] expData = (modelQ.size() > 0) ? modelQ[0] : 8'h00;
      checks++;
      if (rd_valid !== (modelQ.size() > 0)) begin
        errors++;
        $display("[TB] FAIL model_rd_valid got %0b want %0b @%0t", rd_valid, modelQ.size() > 0, $time);
      end
      checks++;
      if (rd_data !== expData) begin
        errors++;
        $display("[TB] FAIL model_rd_data got %02h want %02h @%0t", rd_data, expData, $time);
      end
      checks++;
      if (count !== 4'(modelQ.size())) begin
        errors++;
        $display("[TB] FAIL model_count got %0d want %0d @%0t", count, modelQ.size(), $time);
      end
      checks++;
      if (overflow !== modelOvf) begin
        errors++;
        $display("[TB] FAIL model_overflow got %0b want %0b @%0t", overflow, modelOvf, $time);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %02h want %02h @%0t", name, actual, expected, $time);
    end
  endtask

  // Holds rd_en/clr_ovf for the given number of edges, then drops them.
  task automatic applyStimulus(input logic rdEn, input logic clr, input int cycles);
    rd_en   = rdEn;
    clr_ovf = clr;
    repeat (cycles) @(negedge clk);
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic rdEn, input logic clr);
    rx_data   = data;
    rx_status = 1'b1;
    rd_en     = rdEn;
    clr_ovf   = clr;
    @(negedge clk);
    rx_status = 1'b0;
    rd_en     = 1'b0;
    clr_ovf   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    rx_data   = 8'h00;
    rx_status = 1'b1;
    rd_en     = 1'b0;
    clr_ovf   = 1'b0;
    @(posedge clk);
    cmpEn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_count", 8'(count), 8'd0);
    checkOutput("reset_rd_valid", 8'(rd_valid), 8'd0);
    checkOutput("reset_rd_data", rd_data, 8'h00);
    checkOutput("reset_overflow", 8'(overflow), 8'd0);

    // Level already high at reset release must not push.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no_spurious_push", 8'(count), 8'd0);
    rx_status = 1'b0;
    @(negedge clk);

    // Long frame-done level gives exactly one push.
    rx_data   = 8'hA5;
    rx_status = 1'b1;
    @(negedge clk);
    checkOutput("a5_rd_valid", 8'(rd_valid), 8'd1);
    checkOutput("a5_rd_data", rd_data, 8'hA5);
    checkOutput("a5_count", 8'(count), 8'd1);
    repeat (199) @(negedge clk);
    checkOutput("a5_count_held", 8'(count), 8'd1);
    rx_status = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("a5_drained", 8'(count), 8'd0);

    // Fill, overflow, clear with coincident overflow, then drain in order.
    for (int i = 1; i <= 8; i++) sendFrame(8'(i), 1'b0, 1'b0);
    checkOutput("fill_count", 8'(count), 8'd8);
    checkOutput("fill_no_ovf", 8'(overflow), 8'd0);
    sendFrame(8'h09, 1'b0, 1'b0);
    checkOutput("ovf_count", 8'(count), 8'd8);
    checkOutput("ovf_set", 8'(overflow), 8'd1);
    sendFrame(8'h0A, 1'b0, 1'b1);
    checkOutput("ovf_priority", 8'(overflow), 8'd1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("ovf_cleared", 8'(overflow), 8'd0);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain_order", rd_data, 8'(i));
      applyStimulus(1'b1, 1'b0, 1);
    end
    checkOutput("drain_count", 8'(count), 8'd0);
    checkOutput("drain_rd_data", rd_data, 8'h00);

    // Full FIFO with pop coincident with the push: both happen.
    for (int i = 1; i <= 8; i++) sendFrame(8'(i), 1'b0, 1'b0);
    sendFrame(8'h09, 1'b1, 1'b0);
    checkOutput("fullpp_ovf", 8'(overflow), 8'd0);
    checkOutput("fullpp_count", 8'(count), 8'd8);
    checkOutput("fullpp_head", rd_data, 8'h02);
    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("fullpp_tail", rd_data, 8'h09);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("fullpp_empty", 8'(count), 8'd0);

    // rd_en on empty is ignored; push with rd_en on empty only pushes.
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("empty_rd_count", 8'(count), 8'd0);
    checkOutput("empty_rd_data", rd_data, 8'h00);
    rx_data   = 8'h3C;
    rx_status = 1'b1;
    rd_en     = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("empty_push_count", 8'(count), 8'd1);
    checkOutput("empty_push_data", rd_data, 8'h3C);
    rx_status = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1);

    // Push/pop pairs walk both pointers past the wrap point.
    for (int i = 0; i < 20; i++) begin
      sendFrame(8'h40 + 8'(i), 1'b0, 1'b0);
      checkOutput("wrap_data", rd_data, 8'h40 + 8'(i));
      applyStimulus(1'b1, 1'b0, 1);
    end
    checkOutput("wrap_count", 8'(count), 8'd0);

    // Reset mid-operation discards queue and ignores that cycle's push/pop.
    for (int i = 0; i < 5; i++) sendFrame(8'h60 + 8'(i), 1'b0, 1'b0);
    checkOutput("pre_reset_count", 8'(count), 8'd5);
    reset     = 1'b0;
    rd_en     = 1'b1;
    rx_data   = 8'h77;
    rx_status = 1'b1;
    @(negedge clk);
    checkOutput("midreset_count", 8'(count), 8'd0);
    checkOutput("midreset_rd_valid", 8'(rd_valid), 8'd0);
    checkOutput("midreset_rd_data", rd_data, 8'h00);
    reset     = 1'b1;
    rd_en     = 1'b0;
    rx_status = 1'b0;
    @(negedge clk);
    sendFrame(8'h5A, 1'b0, 1'b0);
    checkOutput("post_reset_data", rd_data, 8'h5A);
    checkOutput("post_reset_count", 8'(count), 8'd1);
    applyStimulus(1'b1, 1'b0, 1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
